mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
Memory-side responder for the multicycle core's unified instruction/data bus. It serves word reads and word/byte writes from a DEPTH-word RAM and adds a programmable wait-state latency through a req/ready handshake. Byte lanes are big-endian: addr[1:0]=0 selects bits 31:24, matching the core's byte-select order. It sits between the core's address/writedata/readdata lines and on-chip RAM.

Parameters:
N, 32, data/address width in bits
DEPTH, 64, RAM size in N-bit words (power of two)
LATENCY, 2, edges from request acceptance to the ready cycle (legal range 1..15)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
req  input  1  access request, held high by the initiator until ready
we  input  1  1 = write, 0 = read; sampled at acceptance
bsize  input  1  1 = byte write (SB), 0 = word write; ignored for reads
addr  input  N  byte address; word index = addr[log2(DEPTH)+1:2]
wdata  input  N  write data; for byte writes the byte is in wdata[7:0]
ready  output  1  one-cycle pulse: access complete, readdata valid
readdata  output  N  registered read word, held until the next read completes
busy  output  1  high in WAIT and DONE
err  output  1  out-of-range flag (see Optional Feature)

Behaviour:
- Reset (reset=0, async): state IDLE, ready=0, busy=0, readdata=0, err=0, counter=0. RAM contents are not cleared.
- FSM states: IDLE, WAIT, DONE.
- IDLE: at a clock edge with req=1, accept the request. Latch addr, wdata, we and bsize. Load counter=LATENCY-1. If LATENCY=1, go to DONE; otherwise go to WAIT.
- WAIT: decrement the counter each edge. At the edge where counter=1, go to DONE. Input changes during WAIT are ignored because the latched copies are used.
- Entering DONE (same edge), read: readdata <= RAM[word]. readdata is always a full word; the initiator extracts the byte.
- Entering DONE (same edge), word write: RAM[word] <= wdata. readdata is unchanged.
- Entering DONE (same edge), byte write: update only lane addr[1:0] with wdata[7:0] (lane 0 = [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0]). Other lanes are kept.
- DONE: ready=1 for exactly this cycle, then go to IDLE unconditionally. req is not sampled in DONE.
- Latency: ready is high in the cycle following LATENCY edges after the acceptance edge. Minimum issue interval is LATENCY+1 cycles.
- A req still high in IDLE after DONE is a new request.
- Word index wraps modulo DEPTH; upper address bits are ignored unless the optional feature is compiled in.
- Reset asserted in WAIT or DONE aborts the access: no RAM write occurs if the abort comes before the DONE-entry edge, and all outputs return to their reset values.

Optional Feature:
Macro MEM_RANGE_CHECK_EN.
- Defined: at acceptance, if addr >= DEPTH*4, the access is marked bad. At DONE entry, a bad write is suppressed, a bad read returns 0, and err=1 during the DONE cycle alongside ready.
- Undefined: err is tied to 0 and addresses wrap.

Decomposition:
- Shared package mem_pkg: state enum (IDLE, WAIT, DONE), lane-index constants, and a function that computes the byte-lane write mask from addr[1:0].
- One sub-module, mem_array: single-port synchronous RAM with a 4-bit byte write enable. The FSM and latency counter stay in mem_responder.

Test Plan:
- Reset then preload: with LATENCY=2, write word 0xDEADBEEF at addr 0x10, then read 0x10 -> ready pulses 2 cycles after each acceptance, readdata=0xDEADBEEF, busy high in WAIT and DONE.
- Byte writes: SB 0xAA at 0x11, then SB 0x55 at 0x13 over word 0xDEADBEEF -> a read returns 0xDEAA BE55.
- LATENCY=1, req held continuously for alternating read/write -> ready every 2nd cycle, with no lost or duplicated accesses.
- Reset asserted mid-WAIT on a write of 0x12345678 to 0x20 -> outputs clear immediately, and a later read of 0x20 returns the prior contents.
- addr/wdata changed during WAIT -> the latched values are used; the changed values have no effect.
- With MEM_RANGE_CHECK_EN and DEPTH=64, write to 0x100 -> err=1 together with ready, and RAM[0] is unchanged. Without the macro, the same write wraps to word 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the memory responder: FSM states, byte-lane numbering and
// the byte-write mask helper.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Big-endian lanes: addr[1:0]=0 addresses the most significant byte.
  localparam logic [1:0] LANE_B31_24 = 2'd0;
  localparam logic [1:0] LANE_B23_16 = 2'd1;
  localparam logic [1:0] LANE_B15_8  = 2'd2;
  localparam logic [1:0] LANE_B7_0   = 2'd3;

  // Byte-enable bit i covers data bits [8*i+7:8*i].
  function automatic logic [3:0] lane_mask(input logic [1:0] off);
    logic [3:0] m;
    m = 4'b0000;
    case (off)
      LANE_B31_24: m = 4'b1000;
      LANE_B23_16: m = 4'b0100;
      LANE_B15_8:  m = 4'b0010;
      LANE_B7_0:   m = 4'b0001;
      default:     m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with byte write enables and a registered read
// port; the read register clears on reset, the storage does not.
module mem_array #(
  parameter  int N     = 32,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_rd,
  input  logic          i_clr,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_idx,
  input  logic [N-1:0]  i_wdata,
  output logic [N-1:0]  o_rdata
);

  logic [N-1:0] r_mem [DEPTH];
  logic [N-1:0] r_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_be[b]) r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
    end
  end

  // i_clr returns zero for a rejected read instead of the stored word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_q <= '0;
    else if (i_rd) r_q <= i_clr ? '0 : r_mem[i_idx];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: req/ready handshake with LATENCY edges from
// acceptance to ready. Define MEM_RANGE_CHECK_EN to flag addresses >= DEPTH*4.
module mem_responder
  import mem_pkg::*;
#(
  parameter int N       = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic         we,
  input  logic         bsize,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] wdata,
  output logic         ready,
  output logic [N-1:0] readdata,
  output logic         busy,
  output logic         err
);

  localparam int AW = $clog2(DEPTH);

  state_t         r_state;
  logic [3:0]     r_cnt;
  logic [AW+1:0]  r_addr;
  logic [N-1:0]   r_wdata;
  logic           r_we, r_bsize, r_bad;
  logic           r_ready, r_busy, r_err;

  logic           w_accept, w_fire, w_idle;
  logic [AW+1:0]  w_addr;
  logic [N-1:0]   w_wdata, w_wd;
  logic           w_we, w_bsize, w_bad, w_bad_in;
  logic [3:0]     w_be;
  logic           w_unused;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = w_idle && req;
  // With LATENCY=1 the access completes on the acceptance edge itself, so
  // the live inputs feed the RAM rather than the (not yet loaded) latches.
  assign w_fire   = (w_accept && (LATENCY == 1)) ||
                    ((r_state == WAIT) && (r_cnt == 4'd1));

  assign w_addr  = w_idle ? addr[AW+1:0] : r_addr;
  assign w_wdata = w_idle ? wdata        : r_wdata;
  assign w_we    = w_idle ? we           : r_we;
  assign w_bsize = w_idle ? bsize        : r_bsize;
  assign w_bad   = w_idle ? w_bad_in     : r_bad;

`ifdef MEM_RANGE_CHECK_EN
  assign w_bad_in = (addr >> (AW + 2)) != '0;
`else
  assign w_bad_in = 1'b0;
`endif
  assign w_unused = &{1'b0, addr[N-1:AW+2]};

  assign w_be = (w_fire && w_we && !w_bad) ?
                (w_bsize ? lane_mask(w_addr[1:0]) : 4'hF) : 4'h0;
  assign w_wd = w_bsize ? {4{w_wdata[7:0]}} : w_wdata;

  mem_array #(.N(N), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .rst_n   (reset),
    .i_rd    (w_fire && !w_we),
    .i_clr   (w_bad),
    .i_be    (w_be),
    .i_idx   (w_addr[AW+1:2]),
    .i_wdata (w_wd),
    .o_rdata (readdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_bsize <= 1'b0;
      r_bad   <= 1'b0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: if (req) begin
          r_addr  <= addr[AW+1:0];
          r_wdata <= wdata;
          r_we    <= we;
          r_bsize <= bsize;
          r_bad   <= w_bad_in;
          r_cnt   <= 4'(LATENCY - 1);
          r_busy  <= 1'b1;
          if (LATENCY == 1) begin
            r_state <= DONE;
            r_ready <= 1'b1;
            r_err   <= w_bad_in;
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= DONE;
            r_ready <= 1'b1;
            r_err   <= r_bad;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready = r_ready;
  assign busy  = r_busy;
  assign err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one LATENCY=2 instance and one LATENCY=1
// instance sharing clock and reset.
module tb_mem_responder;

`ifdef MEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk, rst_n;
  logic        req, we, bsize, ready, busy, err;
  logic [31:0] addr, wdata, readdata;
  logic        req1, we1, bs1, rdy1, busy1, err1;
  logic [31:0] addr1, wdata1, rd1;
  int checks = 0;
  int errors = 0;

  mem_responder #(.N(32), .DEPTH(64), .LATENCY(2)) u_dut (
    .clk(clk), .reset(rst_n), .req(req), .we(we), .bsize(bsize),
    .addr(addr), .wdata(wdata), .ready(ready), .readdata(readdata),
    .busy(busy), .err(err));

  mem_responder #(.N(32), .DEPTH(64), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(rst_n), .req(req1), .we(we1), .bsize(bs1),
    .addr(addr1), .wdata(wdata1), .ready(rdy1), .readdata(rd1),
    .busy(busy1), .err(err1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // One access on the LATENCY=2 instance; optionally swaps addr/wdata/we after
  // the acceptance edge to prove the latched copies are used.
  task automatic acc2(input logic w, input logic bs, input logic [31:0] a,
                      input logic [31:0] d, input logic chg, input logic [31:0] a2,
                      input logic [31:0] d2, output int lat, output logic [31:0] rd,
                      output logic er, output logic bsy_wait, output logic bsy_done);
    req = 1'b1; we = w; bsize = bs; addr = a; wdata = d;
    lat = 0; bsy_wait = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (chg && lat == 1) begin addr = a2; wdata = d2; we = ~w; end
      if (ready) break;
      if (!busy) bsy_wait = 1'b0;
    end
    rd = readdata; er = err; bsy_done = busy;
    req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 0; we = 0; bsize = 0; addr = 0; wdata = 0;
    req1 = 0; we1 = 0; bs1 = 0; addr1 = 0; wdata1 = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ready, busy, err, readdata} !== 35'd0) begin
      errors++; $display("FAIL reset_a: got rdy=%b busy=%b err=%b rd=%h, want all 0", ready, busy, err, readdata);
    end
    checks++;
    if ({rdy1, busy1, err1, rd1} !== 35'd0) begin
      errors++; $display("FAIL reset_b: got rdy=%b busy=%b err=%b rd=%h, want all 0", rdy1, busy1, err1, rd1);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    int lat; logic [31:0] rd; logic er, bw, bd;
    acc2(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 0, 0, lat, rd, er, bw, bd);
    checks++;
    if (lat !== 2 || !bw || !bd || er !== 1'b0) begin
      errors++; $display("FAIL word_write: lat=%0d busy_wait=%b busy_done=%b err=%b, want 2 1 1 0", lat, bw, bd, er);
    end
    checks++;
    if (ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL word_idle: rdy=%b busy=%b, want 0 0", ready, busy);
    end
    acc2(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 0, 0, lat, rd, er, bw, bd);
    checks++;
    if (lat !== 2 || rd !== 32'hDEADBEEF || !bw || !bd) begin
      errors++; $display("FAIL word_read: lat=%0d rd=%h busy=%b/%b, want 2 deadbeef 1/1", lat, rd, bw, bd);
    end
  endtask

  task automatic test_byte();
    int lat; logic [31:0] rd; logic er, bw, bd;
    acc2(1'b1, 1'b1, 32'h11, 32'hFFFFFFAA, 1'b0, 0, 0, lat, rd, er, bw, bd);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL byte_rd_hold: rd=%h, want deadbeef", rd);
    end
    acc2(1'b1, 1'b1, 32'h13, 32'h00000055, 1'b0, 0, 0, lat, rd, er, bw, bd);
    acc2(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 0, 0, lat, rd, er, bw, bd);
    checks++;
    if (rd !== 32'hDEAABE55) begin
      errors++; $display("FAIL byte_merge: rd=%h, want deaabe55", rd);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    logic [31:0] exp;
    req1 = 1'b1; we1 = 1'b1; bs1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h11111111;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      checks++;
      if (rdy1 !== 1'b1) begin
        errors++; $display("FAIL b2b_ready_%0d: rdy=%b, want 1", k, rdy1);
      end
      if (rdy1 === 1'b1) pulses++;
      if (k % 2 == 1) begin
        exp = (k == 1) ? 32'h11111111 : (k == 3) ? 32'h22222222 : 32'h33333333;
        checks++;
        if (rd1 !== exp) begin
          errors++; $display("FAIL b2b_read_%0d: rd=%h, want %h", k, rd1, exp);
        end
      end
      if (k == 5) req1 = 1'b0;
      else if (k % 2 == 0) we1 = 1'b0;
      else begin
        we1 = 1'b1;
        addr1  = (k == 1) ? 32'h4 : 32'h0;
        wdata1 = (k == 1) ? 32'h22222222 : 32'h33333333;
      end
      @(posedge clk); #1;
      checks++;
      if (rdy1 !== 1'b0) begin
        errors++; $display("FAIL b2b_gap_%0d: rdy=%b, want 0", k, rdy1);
      end
    end
    checks++;
    if (pulses !== 6) begin
      errors++; $display("FAIL b2b_count: pulses=%0d, want 6", pulses);
    end
  endtask

  task automatic test_abort();
    int lat; logic [31:0] rd; logic er, bw, bd;
    acc2(1'b1, 1'b0, 32'h20, 32'hCAFEF00D, 1'b0, 0, 0, lat, rd, er, bw, bd);
    acc2(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 0, 0, lat, rd, er, bw, bd);
    req = 1'b1; we = 1'b1; bsize = 1'b0; addr = 32'h20; wdata = 32'h12345678;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      errors++; $display("FAIL abort_wait: busy=%b rdy=%b, want 1 0", busy, ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ready, busy, err, readdata} !== 35'd0) begin
      errors++; $display("FAIL abort_clear: rdy=%b busy=%b err=%b rd=%h, want all 0", ready, busy, err, readdata);
    end
    req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    acc2(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 0, 0, lat, rd, er, bw, bd);
    checks++;
    if (rd !== 32'hCAFEF00D) begin
      errors++; $display("FAIL abort_ram: rd=%h, want cafef00d", rd);
    end
  endtask

  task automatic test_latch();
    int lat; logic [31:0] rd; logic er, bw, bd;
    acc2(1'b1, 1'b0, 32'h28, 32'h5A5A5A5A, 1'b0, 0, 0, lat, rd, er, bw, bd);
    acc2(1'b1, 1'b0, 32'h24, 32'hA5A5A5A5, 1'b1, 32'h28, 32'hFFFFFFFF, lat, rd, er, bw, bd);
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL latch_lat: lat=%0d, want 2", lat);
    end
    acc2(1'b0, 1'b0, 32'h24, 32'h0, 1'b0, 0, 0, lat, rd, er, bw, bd);
    checks++;
    if (rd !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL latch_dst: rd=%h, want a5a5a5a5", rd);
    end
    acc2(1'b0, 1'b0, 32'h28, 32'h0, 1'b0, 0, 0, lat, rd, er, bw, bd);
    checks++;
    if (rd !== 32'h5A5A5A5A) begin
      errors++; $display("FAIL latch_other: rd=%h, want 5a5a5a5a", rd);
    end
  endtask

  task automatic test_range();
    int lat; logic [31:0] rd; logic er, bw, bd;
    logic [31:0] exp0, exp_bad;
    exp0    = RC ? 32'h01020304 : 32'h99999999;
    exp_bad = RC ? 32'h0 : 32'h99999999;
    acc2(1'b1, 1'b0, 32'h00, 32'h01020304, 1'b0, 0, 0, lat, rd, er, bw, bd);
    checks++;
    if (er !== 1'b0) begin
      errors++; $display("FAIL range_ok_err: err=%b, want 0", er);
    end
    acc2(1'b1, 1'b0, 32'h100, 32'h99999999, 1'b0, 0, 0, lat, rd, er, bw, bd);
    checks++;
    if (er !== RC || lat !== 2) begin
      errors++; $display("FAIL range_wr_err: err=%b lat=%0d, want %b 2", er, lat, RC);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL range_err_pulse: err=%b after DONE, want 0", err);
    end
    acc2(1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 0, 0, lat, rd, er, bw, bd);
    checks++;
    if (rd !== exp0) begin
      errors++; $display("FAIL range_word0: rd=%h, want %h", rd, exp0);
    end
    acc2(1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 0, 0, lat, rd, er, bw, bd);
    checks++;
    if (rd !== exp_bad || er !== RC) begin
      errors++; $display("FAIL range_rd: rd=%h err=%b, want %h %b", rd, er, exp_bad, RC);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_back_to_back();
    test_abort();
    test_latch();
    test_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
